// File: rtl/mobo_readout_fsm.sv
// mobo_readout_fsm: readout-side responder of the exposure/readout frame
// handshake. Ports:
//   CLK_ADC, RESET (sync, active-high)
//   FSMIND1 -> FSMIND1ACK   readout request / acknowledge
//   FSMIND0 <- FSMIND0ACK   readout finished / acknowledge
//   ROW_ADDR, ROW_EN, COLGRP  row / column-group sequencing
//   ADC_START, ADC_DONE       TI-ADC conversion handshake
//   FIFO_FULL, FIFO_WR        downstream FIFO write
//   ADC_ERR, fsm_stat, CntFrame  status
module mobo_readout_fsm #(
  parameter int C_NUM_ROWS    = 160,
  parameter int C_NUM_COLGRP  = 4,
  parameter int C_ROW_SETTLE  = 16,
  parameter int C_ADC_TIMEOUT = 1024
) (
  input  logic        CLK_ADC,
  input  logic        RESET,
  input  logic        FSMIND1,
  output logic        FSMIND1ACK,
  output logic        FSMIND0,
  input  logic        FSMIND0ACK,
  output logic [7:0]  ROW_ADDR,
  output logic        ROW_EN,
  output logic [3:0]  COLGRP,
  output logic        ADC_START,
  input  logic        ADC_DONE,
  input  logic        FIFO_FULL,
  output logic        FIFO_WR,
  output logic        ADC_ERR,
  output logic [7:0]  fsm_stat,
  output logic [31:0] CntFrame
);

  localparam int SW = $clog2(C_ROW_SETTLE + 2);
  localparam int TW = $clog2(C_ADC_TIMEOUT + 2);
  localparam logic [7:0]    LAST_ROW = 8'(C_NUM_ROWS - 1);
  localparam logic [3:0]    LAST_COL = 4'(C_NUM_COLGRP - 1);
  localparam logic [SW-1:0] SET_END  = SW'(C_ROW_SETTLE);
  localparam logic [TW-1:0] TO_END   = TW'(C_ADC_TIMEOUT);
  localparam logic [TW-1:0] TO_ERR   = TW'(C_ADC_TIMEOUT - 1);

  typedef enum logic [8:0] {
    S_IDLE    = 9'h001,
    S_ACK     = 9'h002,
    S_ROW     = 9'h004,
    S_SETTLE  = 9'h008,
    S_START   = 9'h010,
    S_CONV    = 9'h020,
    S_WR      = 9'h040,
    S_DONE    = 9'h080,
    S_RELEASE = 9'h100
  } state_t;

  state_t state, state_nxt;

  logic [1:0] ind1_sync, ind0ack_sync;
  logic fsmind1_s, fsmind0ack_s;

  logic [SW-1:0] settle_cnt, settle_cnt_nxt;
  logic [TW-1:0] to_cnt, to_cnt_nxt;
  logic          ack1_nxt, ind0_nxt, row_en_nxt, err_nxt;
  logic [7:0]    row_nxt;
  logic [3:0]    col_nxt;
  logic [31:0]   cnt_nxt;

  assign fsmind1_s    = ind1_sync[1];
  assign fsmind0ack_s = ind0ack_sync[1];

  always_ff @(posedge CLK_ADC) begin
    if (RESET) begin
      state        <= S_IDLE;
      ind1_sync    <= '0;
      ind0ack_sync <= '0;
      settle_cnt   <= '0;
      to_cnt       <= '0;
      FSMIND1ACK   <= 1'b0;
      FSMIND0      <= 1'b0;
      ROW_EN       <= 1'b0;
      ROW_ADDR     <= '0;
      COLGRP       <= '0;
      ADC_ERR      <= 1'b0;
      CntFrame     <= '0;
    end else begin
      state        <= state_nxt;
      ind1_sync    <= {ind1_sync[0], FSMIND1};
      ind0ack_sync <= {ind0ack_sync[0], FSMIND0ACK};
      settle_cnt   <= settle_cnt_nxt;
      to_cnt       <= to_cnt_nxt;
      FSMIND1ACK   <= ack1_nxt;
      FSMIND0      <= ind0_nxt;
      ROW_EN       <= row_en_nxt;
      ROW_ADDR     <= row_nxt;
      COLGRP       <= col_nxt;
      ADC_ERR      <= err_nxt;
      CntFrame     <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    settle_cnt_nxt = settle_cnt;
    to_cnt_nxt     = to_cnt;
    ack1_nxt       = FSMIND1ACK;
    ind0_nxt       = FSMIND0;
    row_en_nxt     = ROW_EN;
    row_nxt        = ROW_ADDR;
    col_nxt        = COLGRP;
    err_nxt        = ADC_ERR;
    cnt_nxt        = CntFrame;
    ADC_START      = 1'b0;
    FIFO_WR        = 1'b0;
    fsm_stat       = 8'h00;
    unique case (state)
      S_IDLE: begin
        fsm_stat   = 8'hF1;
        ack1_nxt   = 1'b0;
        ind0_nxt   = 1'b0;
        row_en_nxt = 1'b0;
        if (fsmind1_s && !fsmind0ack_s)
          state_nxt = S_ACK;
      end
      S_ACK: begin
        fsm_stat  = 8'hF2;
        ack1_nxt  = 1'b1;
        row_nxt   = '0;
        col_nxt   = '0;
        state_nxt = S_ROW;
      end
      S_ROW: begin
        fsm_stat       = 8'hF3;
        row_en_nxt     = 1'b1;
        settle_cnt_nxt = '0;
        state_nxt      = S_SETTLE;
      end
      S_SETTLE: begin
        // Dwell spans SET_END+1 cycles so the first start lands
        // C_ROW_SETTLE+1 cycles after ROW_EN rises.
        fsm_stat = 8'hF4;
        if (settle_cnt == SET_END)
          state_nxt = S_START;
        else
          settle_cnt_nxt = settle_cnt + 1'b1;
      end
      S_START: begin
        fsm_stat = 8'hF5;
        if (!FIFO_FULL) begin
          ADC_START  = 1'b1;
          to_cnt_nxt = TW'(1);
          state_nxt  = S_CONV;
        end
      end
      S_CONV: begin
        // to_cnt equals cycles elapsed since ADC_START.
        fsm_stat = 8'hF6;
        if (ADC_DONE) begin
          state_nxt = S_WR;
        end else if (to_cnt >= TO_END) begin
          err_nxt   = 1'b1;
          state_nxt = S_WR;
        end else begin
          to_cnt_nxt = to_cnt + 1'b1;
          if (to_cnt == TO_ERR)
            err_nxt = 1'b1;
        end
      end
      S_WR: begin
        fsm_stat = 8'hF7;
        if (!FIFO_FULL) begin
          FIFO_WR = 1'b1;
          if (COLGRP < LAST_COL) begin
            col_nxt   = COLGRP + 1'b1;
            state_nxt = S_START;
          end else if (ROW_ADDR < LAST_ROW) begin
            row_nxt    = ROW_ADDR + 1'b1;
            col_nxt    = '0;
            row_en_nxt = 1'b0;
            state_nxt  = S_ROW;
          end else begin
            row_en_nxt = 1'b0;
            ind0_nxt   = 1'b1;
            state_nxt  = S_DONE;
          end
        end
      end
      S_DONE: begin
        fsm_stat = 8'hF8;
        ind0_nxt = 1'b1;
        if (fsmind0ack_s) begin
          ind0_nxt  = 1'b0;
          ack1_nxt  = 1'b0;
          state_nxt = S_RELEASE;
        end
      end
      S_RELEASE: begin
        // Waiting for FSMIND1 low blocks re-triggering on a stale request.
        fsm_stat = 8'hF9;
        ind0_nxt = 1'b0;
        ack1_nxt = 1'b0;
        if (!fsmind1_s) begin
          cnt_nxt   = CntFrame + 32'd1;
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt  = S_IDLE;
        ack1_nxt   = 1'b0;
        ind0_nxt   = 1'b0;
        row_en_nxt = 1'b0;
        row_nxt    = '0;
        col_nxt    = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_mobo_readout_fsm.sv
// tb_mobo_readout_fsm: randomized frame stimulus, ADC responder and
// write scoreboard for mobo_readout_fsm.
module tb_mobo_readout_fsm;

  localparam int NR = 2;
  localparam int NC = 2;
  localparam int ST = 3;
  localparam int TO = 8;
  localparam int NW = NR * NC;

  logic        CLK_ADC = 1'b0;
  logic        RESET;
  logic        FSMIND1;
  logic        FSMIND1ACK;
  logic        FSMIND0;
  logic        FSMIND0ACK;
  logic [7:0]  ROW_ADDR;
  logic        ROW_EN;
  logic [3:0]  COLGRP;
  logic        ADC_START;
  logic        ADC_DONE;
  logic        FIFO_FULL;
  logic        FIFO_WR;
  logic        ADC_ERR;
  logic [7:0]  fsm_stat;
  logic [31:0] CntFrame;

  mobo_readout_fsm #(
    .C_NUM_ROWS(NR), .C_NUM_COLGRP(NC),
    .C_ROW_SETTLE(ST), .C_ADC_TIMEOUT(TO)
  ) dut (
    .CLK_ADC(CLK_ADC), .RESET(RESET),
    .FSMIND1(FSMIND1), .FSMIND1ACK(FSMIND1ACK),
    .FSMIND0(FSMIND0), .FSMIND0ACK(FSMIND0ACK),
    .ROW_ADDR(ROW_ADDR), .ROW_EN(ROW_EN), .COLGRP(COLGRP),
    .ADC_START(ADC_START), .ADC_DONE(ADC_DONE),
    .FIFO_FULL(FIFO_FULL), .FIFO_WR(FIFO_WR),
    .ADC_ERR(ADC_ERR), .fsm_stat(fsm_stat), .CntFrame(CntFrame)
  );

  always #5 CLK_ADC = ~CLK_ADC;

  typedef struct { int row; int col; } word_t;
  word_t sbq[$];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int cnt_model = 0;
  bit err_model = 0;
  bit strict = 0;
  int dly_mode = 0;
  int to_conv = -1;
  int conv_n = 0;
  bit rnd_full = 0;

  always @(posedge CLK_ADC) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic bit cond(input int sel);
    case (sel)
      0:       return FSMIND1ACK;
      1:       return FSMIND0;
      2:       return fsm_stat == 8'hF1;
      3:       return fsm_stat == 8'hF4;
      default: return fsm_stat == 8'hF6 && ROW_ADDR == 8'd1;
    endcase
  endfunction

  task automatic wait_cond(input string nm, input int sel, input int bound);
    bit ok = 0;
    for (int k = 0; k < bound && !ok; k++) begin
      @(negedge CLK_ADC);
      ok = cond(sel);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: condition not reached within %0d cycles", nm, bound);
    end
  endtask

  task automatic push_frame();
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        sbq.push_back('{row: r, col: c});
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_ack1"}, FSMIND1ACK, 0);
    chk({p, "_ind0"}, FSMIND0, 0);
    chk({p, "_rowen"}, ROW_EN, 0);
    chk({p, "_row"}, ROW_ADDR, 0);
    chk({p, "_col"}, COLGRP, 0);
    chk({p, "_start"}, ADC_START, 0);
    chk({p, "_wr"}, FIFO_WR, 0);
    chk({p, "_err"}, ADC_ERR, 0);
    chk({p, "_cnt"}, CntFrame, 0);
    chk({p, "_stat"}, fsm_stat, 8'hF1);
  endtask

  // Scoreboard monitor.
  initial begin
    bit prev_en;
    bit first_pend;
    int rise_c;
    int fell_c;
    word_t w;
    prev_en = 0;
    first_pend = 0;
    rise_c = 0;
    fell_c = -100;
    forever begin
      @(negedge CLK_ADC);
      if (RESET) begin
        prev_en = 0;
        first_pend = 0;
      end else begin
        if (FIFO_FULL)
          chk("no_strobe_when_full", {ADC_START, FIFO_WR}, 0);
        if (ROW_EN && !prev_en) begin
          if (strict && ROW_ADDR != 0)
            chk("row_gap", cyc - fell_c, 1);
          rise_c = cyc;
          first_pend = 1;
        end
        if (!ROW_EN && prev_en)
          fell_c = cyc;
        prev_en = ROW_EN;
        if (ADC_START && first_pend) begin
          first_pend = 0;
          if (strict)
            chk("settle_lat", cyc - rise_c, ST + 1);
        end
        if (FIFO_WR) begin
          wr_cnt++;
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: write row %0d col %0d, none expected",
                     ROW_ADDR, COLGRP);
          end else begin
            w = sbq.pop_front();
            chk("wr_row", ROW_ADDR, w.row);
            chk("wr_col", COLGRP, w.col);
            chk("wr_err", ADC_ERR, err_model);
          end
        end
      end
    end
  end

  // ADC responder.
  initial begin
    int d;
    bit perr;
    ADC_DONE = 0;
    forever begin
      @(negedge CLK_ADC);
      if (ADC_START && !RESET) begin
        if (conv_n == to_conv) begin
          conv_n++;
          perr = err_model;
          err_model = 1;
          repeat (TO - 1) @(negedge CLK_ADC);
          if (!perr) chk("err_early", ADC_ERR, 0);
          @(negedge CLK_ADC);
          chk("err_rise", ADC_ERR, 1);
          @(negedge CLK_ADC);
          if (strict) chk("timeout_wr", FIFO_WR, 1);
        end else begin
          conv_n++;
          d = (dly_mode == 0) ? 4 : int'($urandom_range(1, 6));
          repeat (d) @(posedge CLK_ADC);
          #1 ADC_DONE = 1;
          @(posedge CLK_ADC);
          #1 ADC_DONE = 0;
          if (strict) begin
            @(negedge CLK_ADC);
            chk("done_to_wr", FIFO_WR, 1);
          end
        end
      end
    end
  end

  // Random backpressure.
  initial forever begin
    @(posedge CLK_ADC);
    #1;
    if (rnd_full) FIFO_FULL = ($urandom_range(0, 3) == 0);
  end

  task automatic frame(input int hold, input bit chk_lat);
    int w0;
    int c0;
    @(posedge CLK_ADC);
    #1;
    push_frame();
    conv_n = 0;
    w0 = wr_cnt;
    FSMIND1 = 1;
    c0 = cyc;
    wait_cond("ack_rise", 0, 20);
    if (chk_lat) chk("ack_lat", cyc - c0, 4);
    wait_cond("frame_done", 1, 3000);
    chk("wr_count", wr_cnt - w0, NW);
    @(posedge CLK_ADC);
    #1 FSMIND0ACK = 1;
    repeat (3) @(negedge CLK_ADC);
    chk("ind0_held", FSMIND0, 1);
    @(negedge CLK_ADC);
    chk("ind0_fall", FSMIND0, 0);
    if (hold > 0) begin
      repeat (hold) @(negedge CLK_ADC);
      chk("hold_release", fsm_stat, 8'hF9);
      chk("hold_ack1", FSMIND1ACK, 0);
      chk("hold_no_wr", wr_cnt - w0, NW);
    end
    @(posedge CLK_ADC);
    #1 FSMIND1 = 0;
    wait_cond("back_idle", 2, 20);
    @(posedge CLK_ADC);
    #1 FSMIND0ACK = 0;
    cnt_model++;
    @(negedge CLK_ADC);
    chk("cnt_frame", CntFrame, cnt_model);
    chk("sb_left", sbq.size(), 0);
    repeat (4) @(posedge CLK_ADC);
  endtask

  task automatic bp_seq();
    wait_cond("bp_settle", 3, 200);
    @(posedge CLK_ADC);
    #1 FIFO_FULL = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK_ADC);
      chk("bp_no_start", ADC_START, 0);
    end
    chk("bp_in_start", fsm_stat, 8'hF5);
    @(posedge CLK_ADC);
    #1 FIFO_FULL = 0;
    @(negedge CLK_ADC);
    chk("bp_start_after", ADC_START, 1);
    @(posedge CLK_ADC);
    #1 FIFO_FULL = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK_ADC);
      chk("bp_no_wr", FIFO_WR, 0);
    end
    chk("bp_in_wr", fsm_stat, 8'hF7);
    @(posedge CLK_ADC);
    #1 FIFO_FULL = 0;
    @(negedge CLK_ADC);
    chk("bp_wr_after", FIFO_WR, 1);
  endtask

  task automatic glitch();
    int w0;
    bit seen;
    @(posedge CLK_ADC);
    #1;
    push_frame();
    conv_n = 0;
    w0 = wr_cnt;
    FSMIND1 = 1;
    @(posedge CLK_ADC);
    #1 FSMIND1 = 0;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK_ADC);
      if (FSMIND1ACK) seen = 1;
    end
    if (!seen) begin
      sbq.delete();
      chk("glitch_cnt_same", CntFrame, cnt_model);
      chk("glitch_no_wr", wr_cnt - w0, 0);
    end else begin
      wait_cond("glitch_done", 1, 3000);
      chk("glitch_wr", wr_cnt - w0, NW);
      @(posedge CLK_ADC);
      #1 FSMIND0ACK = 1;
      wait_cond("glitch_idle", 2, 20);
      @(posedge CLK_ADC);
      #1 FSMIND0ACK = 0;
      cnt_model++;
      @(negedge CLK_ADC);
      chk("glitch_cnt", CntFrame, cnt_model);
      chk("glitch_sb_left", sbq.size(), 0);
    end
  endtask

  initial begin
    RESET = 1;
    FSMIND1 = 0;
    FSMIND0ACK = 0;
    FIFO_FULL = 0;
    repeat (2) @(posedge CLK_ADC);
    @(negedge CLK_ADC);
    chk_reset("rst");
    @(posedge CLK_ADC);
    #1 RESET = 0;
    repeat (2) @(posedge CLK_ADC);

    strict = 1;
    dly_mode = 0;
    frame(0, 1);

    strict = 0;
    fork
      frame(0, 0);
      bp_seq();
    join

    strict = 1;
    to_conv = 1;
    frame(20, 1);
    chk("err_sticky", ADC_ERR, 1);
    to_conv = -1;

    strict = 0;
    dly_mode = 1;
    @(posedge CLK_ADC);
    #1;
    push_frame();
    conv_n = 0;
    FSMIND1 = 1;
    wait_cond("row1_conv", 4, 500);
    #1 RESET = 1;
    FSMIND1 = 0;
    @(negedge CLK_ADC);
    chk_reset("abort");
    sbq.delete();
    err_model = 0;
    cnt_model = 0;
    @(posedge CLK_ADC);
    #1 RESET = 0;
    repeat (3) @(posedge CLK_ADC);

    rnd_full = 1;
    repeat (3) frame(0, 0);
    chk("three_frames", CntFrame, 3);
    rnd_full = 0;
    FIFO_FULL = 0;

    glitch();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
